conv_window_sequencer: RTL and testbench

Drives a conv_buffer instance from the consumer side. It walks the output anchor grid and generates `conv_on`, `anchor_l`/`anchor_c` and the element index `buf_l`/`buf_c`. It multiply-accumulates the returned `img_cal`×`wei_cal` pairs and emits one result per output pixel on a valid/ready stream. It sits between the layer controller (`start`/`done`) and the result writer.

---
 rtl/conv_pkg.sv | 25 ++
 rtl/conv_mac_acc.sv | 52 +++++
 rtl/conv_window_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_conv_window_sequencer.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution window sequencer.
//   state_e          : walker FSM state encoding (3-bit)
//   result_dim()     : number of output pixels along one axis
//   acc_width_ok()   : true when an accumulator width cannot overflow a full window
package conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_MAC  = 3'd2,
    ST_EMIT = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  function automatic int unsigned result_dim(input int unsigned img, input int unsigned kern,
                                             input int unsigned pad, input int unsigned stride);
    return (img - kern + 2 * pad) / stride + 1;
  endfunction

  function automatic bit acc_width_ok(input int unsigned acc_w, input int unsigned bw,
                                      input int unsigned n_terms);
    return acc_w >= 2 * bw + $clog2(n_terms);
  endfunction

endpackage

// File: rtl/conv_mac_acc.sv
// Signed multiply-accumulate for one convolution window.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : zero the accumulator (takes priority over en)
//   en         : add sext(a)*sext(b) to the accumulator
//   a, b       : signed two's-complement operands, BITWIDTH bits
//   acc        : running sum, ACC_WIDTH bits, wraps modulo 2^ACC_WIDTH
module conv_mac_acc #(
  parameter int BITWIDTH  = 8,
  parameter int ACC_WIDTH = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  input  logic [BITWIDTH-1:0]  a,
  input  logic [BITWIDTH-1:0]  b,
  output logic [ACC_WIDTH-1:0] acc
);

  logic [2*BITWIDTH-1:0] a_ext;
  logic [2*BITWIDTH-1:0] b_ext;
  logic [2*BITWIDTH-1:0] prod;
  logic [ACC_WIDTH-1:0]  prod_ext;
  logic [ACC_WIDTH-1:0]  acc_d;
  logic [ACC_WIDTH-1:0]  acc_q;

  always_comb begin
    // Low 2*BITWIDTH bits of the product of sign-extended operands equal the
    // signed product, so a plain multiply is sufficient.
    a_ext    = {{BITWIDTH{a[BITWIDTH-1]}}, a};
    b_ext    = {{BITWIDTH{b[BITWIDTH-1]}}, b};
    prod     = a_ext * b_ext;
    prod_ext = {{(ACC_WIDTH - 2*BITWIDTH + 1){prod[2*BITWIDTH-1]}}, prod[2*BITWIDTH-2:0]};
    acc_d    = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + prod_ext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/conv_window_sequencer.sv
// Consumer-side driver for a conv_buffer: walks the output anchor grid, steps
// the kernel element index, accumulates img_cal*wei_cal and streams one result
// per output pixel.
//   clk_en, rst_n            : clock, asynchronous active-low reset
//   start / busy / done      : layer-controller handshake
//   conv_on, anchor_l/_c     : window enable and top-left corner (padded coords)
//   buf_l / buf_c            : kernel element row/column index
//   img_cal / wei_cal        : element pair returned combinationally by conv_buffer
//   result_valid/_ready      : output stream handshake
//   result_data/_l/_c        : dot product and its output-grid coordinates
module conv_window_sequencer
  import conv_pkg::*;
#(
  parameter int WEIGHT_W  = 2,
  parameter int WEIGHT_H  = 2,
  parameter int IMG_W     = 4,
  parameter int IMG_H     = 4,
  parameter int PADDING   = 0,
  parameter int STRIDE    = 1,
  parameter int BITWIDTH  = 8,
  parameter int ACC_WIDTH = 20
) (
  input  logic                 clk_en,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 conv_on,
  output logic [31:0]          anchor_l,
  output logic [31:0]          anchor_c,
  output logic [3:0]           buf_l,
  output logic [3:0]           buf_c,
  input  logic [BITWIDTH-1:0]  img_cal,
  input  logic [BITWIDTH-1:0]  wei_cal,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [ACC_WIDTH-1:0] result_data,
  output logic [15:0]          result_l,
  output logic [15:0]          result_c
);

  localparam int unsigned RESULT_W = result_dim(IMG_W, WEIGHT_W, PADDING, STRIDE);
  localparam int unsigned RESULT_H = result_dim(IMG_H, WEIGHT_H, PADDING, STRIDE);

  localparam logic [3:0]  BUF_C_LAST = 4'(WEIGHT_W - 1);
  localparam logic [3:0]  BUF_L_LAST = 4'(WEIGHT_H - 1);
  localparam logic [15:0] OUT_C_LAST = 16'(RESULT_W - 1);
  localparam logic [15:0] OUT_L_LAST = 16'(RESULT_H - 1);
  localparam logic [31:0] STEP       = 32'(STRIDE);

  if (!acc_width_ok(ACC_WIDTH, BITWIDTH, WEIGHT_W * WEIGHT_H)) begin : g_acc_width_too_small
    $error("conv_window_sequencer: ACC_WIDTH too small for a full window sum");
  end

  state_e      state_q, state_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        conv_on_q, conv_on_d;
  logic        valid_q, valid_d;
  logic [31:0] anchor_l_q, anchor_l_d;
  logic [31:0] anchor_c_q, anchor_c_d;
  logic [3:0]  buf_l_q, buf_l_d;
  logic [3:0]  buf_c_q, buf_c_d;
  logic [15:0] out_l_q, out_l_d;
  logic [15:0] out_c_q, out_c_d;

  logic                 acc_clr;
  logic                 acc_en;
  logic [ACC_WIDTH-1:0] acc;

  // The window is captured in LOAD, so the accumulator is cleared there and
  // the MAC cycles consume one element pair each with no pipeline delay.
  assign acc_clr = (state_q == ST_LOAD);
  assign acc_en  = (state_q == ST_MAC);

  conv_mac_acc #(
    .BITWIDTH (BITWIDTH),
    .ACC_WIDTH(ACC_WIDTH)
  ) u_mac (
    .clk  (clk_en),
    .rst_n(rst_n),
    .clr  (acc_clr),
    .en   (acc_en),
    .a    (img_cal),
    .b    (wei_cal),
    .acc  (acc)
  );

  always_comb begin
    state_d    = state_q;
    conv_on_d  = conv_on_q;
    valid_d    = valid_q;
    anchor_l_d = anchor_l_q;
    anchor_c_d = anchor_c_q;
    buf_l_d    = buf_l_q;
    buf_c_d    = buf_c_q;
    out_l_d    = out_l_q;
    out_c_d    = out_c_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_LOAD;
          conv_on_d  = 1'b1;
          anchor_l_d = '0;
          anchor_c_d = '0;
          out_l_d    = '0;
          out_c_d    = '0;
          buf_l_d    = '0;
          buf_c_d    = '0;
        end
      end
      ST_LOAD: begin
        state_d = ST_MAC;
        buf_l_d = '0;
        buf_c_d = '0;
      end
      ST_MAC: begin
        if (buf_c_q == BUF_C_LAST) begin
          buf_c_d = '0;
          if (buf_l_q == BUF_L_LAST) begin
            buf_l_d = '0;
            valid_d = 1'b1;
            state_d = ST_EMIT;
          end else begin
            buf_l_d = buf_l_q + 4'd1;
          end
        end else begin
          buf_c_d = buf_c_q + 4'd1;
        end
      end
      ST_EMIT: begin
        if (valid_q && result_ready) begin
          valid_d = 1'b0;
          if (out_c_q < OUT_C_LAST) begin
            out_c_d    = out_c_q + 16'd1;
            anchor_c_d = anchor_c_q + STEP;
            state_d    = ST_LOAD;
          end else if (out_l_q < OUT_L_LAST) begin
            out_c_d    = '0;
            anchor_c_d = '0;
            out_l_d    = out_l_q + 16'd1;
            anchor_l_d = anchor_l_q + STEP;
            state_d    = ST_LOAD;
          end else begin
            conv_on_d  = 1'b0;
            anchor_l_d = '0;
            anchor_c_d = '0;
            buf_l_d    = '0;
            buf_c_d    = '0;
            state_d    = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        conv_on_d = 1'b0;
        valid_d   = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_en or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      conv_on_q  <= 1'b0;
      valid_q    <= 1'b0;
      anchor_l_q <= '0;
      anchor_c_q <= '0;
      buf_l_q    <= '0;
      buf_c_q    <= '0;
      out_l_q    <= '0;
      out_c_q    <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      conv_on_q  <= conv_on_d;
      valid_q    <= valid_d;
      anchor_l_q <= anchor_l_d;
      anchor_c_q <= anchor_c_d;
      buf_l_q    <= buf_l_d;
      buf_c_q    <= buf_c_d;
      out_l_q    <= out_l_d;
      out_c_q    <= out_c_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign conv_on      = conv_on_q;
  assign anchor_l     = anchor_l_q;
  assign anchor_c     = anchor_c_q;
  assign buf_l        = buf_l_q;
  assign buf_c        = buf_c_q;
  assign result_valid = valid_q;
  assign result_data  = acc;
  assign result_l     = out_l_q;
  assign result_c     = out_c_q;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Bench for conv_window_sequencer: one instance with default geometry and one
// with PADDING=1. A behavioural conv_buffer answers img_cal/wei_cal from the
// walker outputs; expected results are computed from the bench image/weights.
module tb_conv_window_sequencer;

  logic clk_en = 1'b0;
  always #5 clk_en = ~clk_en;

  logic rst_n;
  logic result_ready;

  logic        start_a, busy_a, done_a, conv_on_a, valid_a;
  logic [31:0] anchor_l_a, anchor_c_a;
  logic [3:0]  buf_l_a, buf_c_a;
  logic [7:0]  img_cal_a, wei_cal_a;
  logic [19:0] data_a;
  logic [15:0] res_l_a, res_c_a;

  logic        start_b, busy_b, done_b, conv_on_b, valid_b;
  logic [31:0] anchor_l_b, anchor_c_b;
  logic [3:0]  buf_l_b, buf_c_b;
  logic [7:0]  img_cal_b, wei_cal_b;
  logic [19:0] data_b;
  logic [15:0] res_l_b, res_c_b;

  conv_window_sequencer #(
    .WEIGHT_W(2), .WEIGHT_H(2), .IMG_W(4), .IMG_H(4),
    .PADDING(0), .STRIDE(1), .BITWIDTH(8), .ACC_WIDTH(20)
  ) dut_a (
    .clk_en(clk_en), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
    .conv_on(conv_on_a), .anchor_l(anchor_l_a), .anchor_c(anchor_c_a),
    .buf_l(buf_l_a), .buf_c(buf_c_a), .img_cal(img_cal_a), .wei_cal(wei_cal_a),
    .result_valid(valid_a), .result_ready(result_ready), .result_data(data_a),
    .result_l(res_l_a), .result_c(res_c_a)
  );

  conv_window_sequencer #(
    .WEIGHT_W(2), .WEIGHT_H(2), .IMG_W(4), .IMG_H(4),
    .PADDING(1), .STRIDE(1), .BITWIDTH(8), .ACC_WIDTH(20)
  ) dut_b (
    .clk_en(clk_en), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
    .conv_on(conv_on_b), .anchor_l(anchor_l_b), .anchor_c(anchor_c_b),
    .buf_l(buf_l_b), .buf_c(buf_c_b), .img_cal(img_cal_b), .wei_cal(wei_cal_b),
    .result_valid(valid_b), .result_ready(result_ready), .result_data(data_b),
    .result_l(res_l_b), .result_c(res_c_b)
  );

  // Image (4x4, row-major) and weights (2x2, row-major)
  logic [7:0] img_mem [16];
  logic [7:0] wei_mem [4];

  // Behavioural conv_buffer for each instance
  always_comb begin
    int ra, ca, ka;
    ra = int'(anchor_l_a) + int'(buf_l_a);
    ca = int'(anchor_c_a) + int'(buf_c_a);
    ka = int'(buf_l_a) * 2 + int'(buf_c_a);
    img_cal_a = (ra >= 0 && ra < 4 && ca >= 0 && ca < 4) ? img_mem[4'(ra * 4 + ca)] : 8'h00;
    wei_cal_a = (ka < 4) ? wei_mem[2'(ka)] : 8'h00;
  end

  always_comb begin
    int rb, cb, kb;
    rb = int'(anchor_l_b) + int'(buf_l_b) - 1;
    cb = int'(anchor_c_b) + int'(buf_c_b) - 1;
    kb = int'(buf_l_b) * 2 + int'(buf_c_b);
    img_cal_b = (rb >= 0 && rb < 4 && cb >= 0 && cb < 4) ? img_mem[4'(rb * 4 + cb)] : 8'h00;
    wei_cal_b = (kb < 4) ? wei_mem[2'(kb)] : 8'h00;
  end

  // Checking infrastructure
  int n_checks = 0;
  int n_err    = 0;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endfunction

  typedef struct {
    logic [15:0] l;
    logic [15:0] c;
    logic [19:0] data;
  } exp_t;

  exp_t sb_q[$];

  function automatic logic [19:0] exp_result(input int pad, input int l, input int c);
    int sum;
    sum = 0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        int r, cc;
        r  = l + i - pad;
        cc = c + j - pad;
        if (r >= 0 && r < 4 && cc >= 0 && cc < 4)
          sum += int'($signed(img_mem[r * 4 + cc])) * int'($signed(wei_mem[i * 2 + j]));
      end
    end
    return 20'(sum);
  endfunction

  // Monitor, watching whichever instance sel points at
  logic        sel;
  logic        chk_interval;
  logic        m_valid, m_done, m_busy, m_conv_on;
  logic [19:0] m_data;
  logic [15:0] m_l, m_c;
  logic [31:0] m_al, m_ac;
  logic [3:0]  m_bl, m_bc;

  always_comb begin
    m_valid   = sel ? valid_b    : valid_a;
    m_done    = sel ? done_b     : done_a;
    m_busy    = sel ? busy_b     : busy_a;
    m_conv_on = sel ? conv_on_b  : conv_on_a;
    m_data    = sel ? data_b     : data_a;
    m_l       = sel ? res_l_b    : res_l_a;
    m_c       = sel ? res_c_b    : res_c_a;
    m_al      = sel ? anchor_l_b : anchor_l_a;
    m_ac      = sel ? anchor_c_b : anchor_c_a;
    m_bl      = sel ? buf_l_b    : buf_l_a;
    m_bc      = sel ? buf_c_b    : buf_c_a;
  end

  int          cycle = 0;
  int          last_hs = -1;
  int          res_n = 0;
  int          done_n = 0;
  logic        done_prev = 1'b0;
  logic [31:0] max_al, max_ac;
  logic [19:0] res_log [32];

  always @(negedge clk_en) begin
    exp_t e;
    cycle++;
    if (!rst_n) begin
      done_prev = 1'b0;
    end else begin
      if (m_valid && result_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_result", 32'(res_n), 32'hFFFF_FFFF);
        end else begin
          e = sb_q.pop_front();
          chk($sformatf("data(%0d,%0d)", e.l, e.c), 32'(m_data), 32'(e.data));
          chk("result_l", 32'(m_l), 32'(e.l));
          chk("result_c", 32'(m_c), 32'(e.c));
          chk("anchor_l_at_result", m_al, 32'(e.l));
          chk("anchor_c_at_result", m_ac, 32'(e.c));
        end
        if (res_n < 32) res_log[5'(res_n)] = m_data;
        res_n++;
        if (chk_interval && last_hs >= 0) chk("result_interval", 32'(cycle - last_hs), 32'd6);
        last_hs = cycle;
        if (m_al > max_al) max_al = m_al;
        if (m_ac > max_ac) max_ac = m_ac;
      end
      if (m_done) begin
        done_n++;
        chk("busy_during_done", 32'(m_busy), 32'd1);
        chk("conv_on_during_done", 32'(m_conv_on), 32'd0);
        chk("anchors_during_done", m_al | m_ac, 32'd0);
        chk("buf_during_done", 32'({m_bl, m_bc}), 32'd0);
      end else if (done_prev) begin
        chk("busy_after_done", 32'(m_busy), 32'd0);
      end
      done_prev = m_done;
    end
  end

  // Stimulus helpers
  task automatic load_img(input int kind, input logic [31:0] wei);
    for (int k = 0; k < 16; k++)
      img_mem[k] = (kind == 0) ? 8'h01 : (kind == 1) ? 8'(k) : 8'hFF;
    for (int k = 0; k < 4; k++)
      wei_mem[k] = wei[k*8 +: 8];
  endtask

  task automatic push_exp(input logic use_b);
    int pad, dim;
    pad = use_b ? 1 : 0;
    dim = use_b ? 5 : 3;
    for (int l = 0; l < dim; l++)
      for (int c = 0; c < dim; c++)
        sb_q.push_back('{l: 16'(l), c: 16'(c), data: exp_result(pad, l, c)});
  endtask

  task automatic prep_run(input logic use_b, input logic interval);
    sel          = use_b;
    chk_interval = interval;
    last_hs      = -1;
    res_n        = 0;
    done_n       = 0;
    max_al       = '0;
    max_ac       = '0;
    sb_q.delete();
    push_exp(use_b);
  endtask

  task automatic pulse_start(input logic use_b);
    @(posedge clk_en); #1;
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk_en); #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic finish_run(input int n_exp);
    int t;
    t = 0;
    while (done_n == 0 && t < 3000) begin
      @(posedge clk_en); #1;
      t++;
    end
    chk("done_before_timeout", 32'(done_n != 0), 32'd1);
    repeat (3) @(posedge clk_en);
    #1;
    chk("result_count", 32'(res_n), 32'(n_exp));
    chk("done_pulses", 32'(done_n), 32'd1);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  task automatic run_map(input logic use_b, input int n_exp, input logic extra_start);
    prep_run(use_b, 1'b1);
    pulse_start(use_b);
    if (extra_start) begin
      repeat (8) @(posedge clk_en);
      #1;
      start_a = 1'b1;
      @(posedge clk_en); #1;
      start_a = 1'b0;
    end
    finish_run(n_exp);
  endtask

  typedef struct {
    int               img_kind;
    logic [31:0]      wei;
    logic             use_b;
    int               n_exp;
    logic [3:0][4:0]  spot_idx;
    logic [3:0][19:0] spot_val;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int   t;
    logic seen_valid;

    rst_n        = 1'b0;
    start_a      = 1'b0;
    start_b      = 1'b0;
    result_ready = 1'b1;
    sel          = 1'b0;
    chk_interval = 1'b0;
    max_al       = '0;
    max_ac       = '0;
    load_img(0, 32'h01010101);

    // kind: 0 = all ones, 1 = ramp k, 2 = all 0xFF; weights packed byte k = w[k]
    vecs[0] = '{0, 32'h01010101, 1'b0, 9,
                {5'd8, 5'd4, 5'd1, 5'd0}, {20'd4, 20'd4, 20'd4, 20'd4}};
    vecs[1] = '{1, 32'h01000001, 1'b0, 9,
                {5'd8, 5'd3, 5'd1, 5'd0}, {20'd25, 20'd13, 20'd7, 20'd5}};
    vecs[2] = '{2, 32'h02020202, 1'b0, 9,
                {5'd8, 5'd5, 5'd1, 5'd0}, {20'hFFFF8, 20'hFFFF8, 20'hFFFF8, 20'hFFFF8}};
    vecs[3] = '{0, 32'h01010101, 1'b1, 25,
                {5'd24, 5'd6, 5'd1, 5'd0}, {20'd1, 20'd4, 20'd2, 20'd1}};

    #12;
    chk("reset_busy",    32'({busy_a, busy_b}), 32'd0);
    chk("reset_done",    32'({done_a, done_b}), 32'd0);
    chk("reset_conv_on", 32'({conv_on_a, conv_on_b}), 32'd0);
    chk("reset_valid",   32'({valid_a, valid_b}), 32'd0);
    chk("reset_anchors", anchor_l_a | anchor_c_a | anchor_l_b | anchor_c_b, 32'd0);
    chk("reset_buf",     32'({buf_l_a, buf_c_a, buf_l_b, buf_c_b}), 32'd0);
    chk("reset_data",    32'(data_a | data_b), 32'd0);
    chk("reset_res_lc",  32'({res_l_a | res_l_b, res_c_a | res_c_b}), 32'd0);
    @(posedge clk_en); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk_en);

    for (int v = 0; v < 4; v++) begin
      load_img(vecs[v].img_kind, vecs[v].wei);
      run_map(vecs[v].use_b, vecs[v].n_exp, 1'b0);
      for (int s = 0; s < 4; s++)
        chk($sformatf("vec%0d_spot%0d", v, vecs[v].spot_idx[s]),
            32'(res_log[vecs[v].spot_idx[s]]), 32'(vecs[v].spot_val[s]));
      if (vecs[v].use_b) begin
        chk("pad_anchor_l_max", max_al, 32'd4);
        chk("pad_anchor_c_max", max_ac, 32'd4);
      end
    end

    // Backpressure at the first EMIT
    load_img(0, 32'h01010101);
    prep_run(1'b0, 1'b0);
    result_ready = 1'b0;
    pulse_start(1'b0);
    t = 0;
    while (!valid_a && t < 100) begin
      @(posedge clk_en); #1;
      t++;
    end
    chk("bp_valid_seen", 32'(valid_a), 32'd1);
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid_held", 32'(valid_a), 32'd1);
      chk("bp_data_held", 32'(data_a), 32'd4);
      chk("bp_anchors_held", anchor_l_a | anchor_c_a, 32'd0);
      chk("bp_conv_on_held", 32'(conv_on_a), 32'd1);
      @(posedge clk_en); #1;
    end
    result_ready = 1'b1;
    finish_run(9);

    // Reset in the middle of the third pixel's MAC phase
    prep_run(1'b0, 1'b1);
    pulse_start(1'b0);
    t = 0;
    while (res_n < 2 && t < 200) begin
      @(posedge clk_en); #1;
      t++;
    end
    @(posedge clk_en); #1;
    @(posedge clk_en); #1;
    chk("mid_mac_buf_c", 32'(buf_c_a), 32'd1);
    chk("mid_mac_anchor_c", anchor_c_a, 32'd2);
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy_a), 32'd0);
    chk("async_rst_conv_on", 32'(conv_on_a), 32'd0);
    chk("async_rst_anchors", anchor_l_a | anchor_c_a, 32'd0);
    chk("async_rst_buf", 32'({buf_l_a, buf_c_a}), 32'd0);
    chk("async_rst_valid", 32'(valid_a), 32'd0);
    chk("async_rst_data", 32'(data_a), 32'd0);
    chk("async_rst_res_lc", 32'({res_l_a, res_c_a}), 32'd0);
    sb_q.delete();
    @(posedge clk_en); #1;
    rst_n = 1'b1;
    seen_valid = 1'b0;
    repeat (10) begin
      @(posedge clk_en); #1;
      if (valid_a || busy_a) seen_valid = 1'b1;
    end
    chk("idle_after_reset", 32'(seen_valid), 32'd0);

    // Fresh start with a spurious start while busy; must match the first map
    run_map(1'b0, 9, 1'b1);
    for (int k = 0; k < 9; k++)
      chk($sformatf("rerun_result%0d", k), 32'(res_log[k]), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
